xfer_counter_fsm: RTL and testbench

XFER_COUNTER_FSM -- requirements
Module: xfer_counter_fsm

---
 rtl/xfer_pkg.sv | 18 +
 rtl/xfer_addr_cnt.sv | 40 ++++
 rtl/xfer_counter_fsm.sv | 138 +++++++++++++
 tb/tb_xfer_counter_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
`default_nettype none
// xfer_pkg: state encoding and default widths shared by the transfer block.
// Revision 1.0
package xfer_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/xfer_addr_cnt.sv
`default_nettype none
// xfer_addr_cnt: loads and steps source/destination addresses and the remaining word count.
// Revision 1.0
module xfer_addr_cnt
  import xfer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [LEN_W-1:0]  remain
);

  // Addresses wrap naturally modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_addr <= '0;
      dst_addr <= '0;
      remain   <= '0;
    end else if (load) begin
      src_addr <= src_in;
      dst_addr <= dst_in;
      remain   <= len_in;
    end else if (step) begin
      src_addr <= src_addr + ADDR_W'(1);
      dst_addr <= dst_addr + ADDR_W'(1);
      remain   <= remain - LEN_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/xfer_counter_fsm.sv
`default_nettype none
// xfer_counter_fsm: one-word-buffered memory copy engine (read, then write, per word).
// Revision 1.0 -- optional abort port pair enabled by macro XFER_ABORT_EN.
module xfer_counter_fsm
  import xfer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_gnt_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic              wr_gnt_i,
  output logic              read_o,
  output logic              write_o,
  output logic              idle_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  remain_o
`ifdef XFER_ABORT_EN
  ,
  input  logic              abort_i,
  output logic              aborted_o
`endif
);

  state_t            state;
  state_t            nxt;
  logic              load;
  logic              step;
  logic              capture;
  logic              abort_req;
  logic [DATA_W-1:0] buffer;

`ifdef XFER_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            load = 1'b1;
            nxt  = READ;
          end else begin
            nxt = DONE;
          end
        end
      end
      READ: begin
        if (abort_req) begin
          nxt = DONE;
        end else if (rd_gnt_i) begin
          capture = 1'b1;
          nxt     = WRITE;
        end
      end
      WRITE: begin
        if (abort_req) begin
          nxt = DONE;
        end else if (wr_gnt_i) begin
          step = 1'b1;
          nxt  = (remain_o == LEN_W'(1)) ? DONE : READ;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Status and request flags are flops mirroring the next state, so they
  // always equal a decode of the state register with no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      read_o   <= 1'b0;
      write_o  <= 1'b0;
      idle_o   <= 1'b1;
      done_o   <= 1'b0;
      rd_req_o <= 1'b0;
      wr_req_o <= 1'b0;
      buffer   <= '0;
`ifdef XFER_ABORT_EN
      aborted_o <= 1'b0;
`endif
    end else begin
      state    <= nxt;
      read_o   <= (nxt == READ);
      write_o  <= (nxt == WRITE);
      idle_o   <= (nxt == IDLE);
      done_o   <= (nxt == DONE);
      rd_req_o <= (nxt == READ);
      wr_req_o <= (nxt == WRITE);
      if (capture) begin
        buffer <= rd_data_i;
      end
`ifdef XFER_ABORT_EN
      aborted_o <= abort_req && ((state == READ) || (state == WRITE));
`endif
    end
  end

  assign wr_data_o = buffer;

  xfer_addr_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .src_in   (src_addr_i),
    .dst_in   (dst_addr_i),
    .len_in   (len_i),
    .src_addr (rd_addr_o),
    .dst_addr (wr_addr_o),
    .remain   (remain_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_xfer_counter_fsm.sv
`default_nettype none
// tb_xfer_counter_fsm: directed and randomized transfers checked against a word-by-word copy model.
// Revision 1.0
module tb_xfer_counter_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] src_addr_i, dst_addr_i, len_i;
  logic        rd_req_o, rd_gnt_i, wr_req_o, wr_gnt_i;
  logic [15:0] rd_addr_o, wr_addr_o, remain_o;
  logic [31:0] rd_data_i, wr_data_o;
  logic        read_o, write_o, idle_o, done_o;
`ifdef XFER_ABORT_EN
  logic        abort_i;
  logic        aborted_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xfer_counter_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .rd_req_o   (rd_req_o),
    .rd_addr_o  (rd_addr_o),
    .rd_gnt_i   (rd_gnt_i),
    .rd_data_i  (rd_data_i),
    .wr_req_o   (wr_req_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_gnt_i   (wr_gnt_i),
    .read_o     (read_o),
    .write_o    (write_o),
    .idle_o     (idle_o),
    .done_o     (done_o),
    .remain_o   (remain_o)
`ifdef XFER_ABORT_EN
    ,
    .abort_i    (abort_i),
    .aborted_o  (aborted_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", 64'($countones({read_o, write_o, idle_o, done_o})), 64'd1);
  endtask

  // Model: word k is read from src+k and written to dst+k, carrying the data
  // presented in its read-grant cycle; done follows the last write grant.
  // A negative wait selects a random 0..3 cycle grant delay.
  task automatic run_xfer(input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input int rd_wait, input int wr_wait);
    logic [15:0] ea, er;
    logic [31:0] d;
    int w;
    chk("pre_idle", idle_o, 1);
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = len;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
    src_addr_i = 16'($urandom);
    dst_addr_i = 16'($urandom);
    if (len == 16'd0) begin
      chk("zero_done", done_o, 1);
      chk("zero_rdreq", rd_req_o, 0);
      chk("zero_wrreq", wr_req_o, 0);
      tick();
      chk("zero_idle", idle_o, 1);
      chk("zero_rdreq2", rd_req_o, 0);
      return;
    end
    d = '0;
    for (int k = 0; k < int'(len); k++) begin
      er = len - 16'(k);
      ea = src + 16'(k);
      w  = (rd_wait < 0) ? int'($urandom_range(3, 0)) : rd_wait;
      for (int i = 0; i <= w; i++) begin
        chk("rd_req", rd_req_o, 1);
        chk("rd_addr", rd_addr_o, ea);
        chk("read_o", read_o, 1);
        chk("remain_rd", remain_o, er);
        rd_data_i = $urandom;
        wr_gnt_i  = 1'($urandom_range(1, 0));
        start_i   = 1'($urandom_range(1, 0));
        len_i     = 16'($urandom);
        rd_gnt_i  = (i == w);
        if (i == w) d = rd_data_i;
        tick();
      end
      rd_gnt_i = 1'b0;
      wr_gnt_i = 1'b0;
      ea = dst + 16'(k);
      w  = (wr_wait < 0) ? int'($urandom_range(3, 0)) : wr_wait;
      for (int i = 0; i <= w; i++) begin
        chk("wr_req", wr_req_o, 1);
        chk("wr_addr", wr_addr_o, ea);
        chk("wr_data", wr_data_o, d);
        chk("write_o", write_o, 1);
        chk("rd_req_in_wr", rd_req_o, 0);
        chk("remain_wr", remain_o, er);
        rd_data_i = $urandom;
        rd_gnt_i  = 1'($urandom_range(1, 0));
        start_i   = 1'($urandom_range(1, 0));
        wr_gnt_i  = (i == w);
        tick();
      end
      rd_gnt_i = 1'b0;
      wr_gnt_i = 1'b0;
      start_i  = 1'b0;
    end
    chk("done", done_o, 1);
    chk("remain_end", remain_o, 0);
    chk("done_noreq", 64'({rd_req_o, wr_req_o}), 0);
`ifdef XFER_ABORT_EN
    chk("aborted_normal", aborted_o, 0);
`endif
    tick();
    chk("done_once", done_o, 0);
    chk("post_idle", idle_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] s5_src, s5_dst;
    rst = 1'b1; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    rd_gnt_i = 1'b0; wr_gnt_i = 1'b0; rd_data_i = '0;
`ifdef XFER_ABORT_EN
    abort_i = 1'b0;
`endif
    tick();
    tick();
    chk("rst_idle", idle_o, 1);
    chk("rst_flags", 64'({read_o, write_o, done_o, rd_req_o, wr_req_o}), 0);
    chk("rst_remain", remain_o, 0);
    chk("rst_rdaddr", rd_addr_o, 0);
    chk("rst_wraddr", wr_addr_o, 0);
    chk("rst_buf", wr_data_o, 0);
    rst = 1'b0;
    tick();

    // Scenario 1: len 3 with immediate grants, done at cycle 7 after start.
    run_xfer(16'h0010, 16'h0100, 16'd3, 0, 0);
    // Scenario 2: zero-length request.
    run_xfer(16'h1234, 16'h5678, 16'd0, 0, 0);
    // Scenario 3: read grant withheld for 5 cycles.
    run_xfer(16'h0200, 16'h0300, 16'd1, 5, 0);
    // Scenario 4: source address wraps.
    run_xfer(16'hFFFF, 16'h0040, 16'd2, 0, 1);

    // Scenario 5: reset during WRITE of a len 4 transfer, after ignored start pulses.
    s5_src = 16'h0A00; s5_dst = 16'h0B00;
    src_addr_i = s5_src; dst_addr_i = s5_dst; len_i = 16'd4; start_i = 1'b1;
    tick();
    chk("s5_read", read_o, 1);
    src_addr_i = 16'h7777; dst_addr_i = 16'h8888; len_i = 16'd9;
    rd_gnt_i = 1'b1;
    tick();
    rd_gnt_i = 1'b0;
    chk("s5_write", write_o, 1);
    wr_gnt_i = 1'b1;
    tick();
    wr_gnt_i = 1'b0; start_i = 1'b0;
    chk("s5_remain", remain_o, 3);
    chk("s5_rdaddr", rd_addr_o, s5_src + 16'd1);
    rd_gnt_i = 1'b1;
    tick();
    rd_gnt_i = 1'b0;
    chk("s5_write2", write_o, 1);
    rst = 1'b1; wr_gnt_i = 1'b1;
    tick();
    rst = 1'b0; wr_gnt_i = 1'b0;
    chk("s5_idle", idle_o, 1);
    chk("s5_remain0", remain_o, 0);
    chk("s5_nodone", done_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_nodone_after", done_o, 0);
    end

`ifdef XFER_ABORT_EN
    // Scenario 6: abort in the second READ of a len 5 transfer.
    src_addr_i = 16'h0C00; dst_addr_i = 16'h0D00; len_i = 16'd5; start_i = 1'b1;
    tick();
    start_i = 1'b0; rd_gnt_i = 1'b1;
    tick();
    rd_gnt_i = 1'b0; wr_gnt_i = 1'b1;
    tick();
    wr_gnt_i = 1'b0;
    chk("s6_read2", read_o, 1);
    abort_i = 1'b1; rd_gnt_i = 1'b1;
    tick();
    abort_i = 1'b0; rd_gnt_i = 1'b0;
    chk("s6_done", done_o, 1);
    chk("s6_aborted", aborted_o, 1);
    chk("s6_remain", remain_o, 4);
    chk("s6_rdaddr", rd_addr_o, 16'h0C01);
    chk("s6_noreq", 64'({rd_req_o, wr_req_o}), 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("s6_idle", idle_o, 1);
    chk("s6_aborted_clr", aborted_o, 0);
`endif

    // Randomized transfers, including zero length and random grant delays.
    for (int t = 0; t < 8; t++) begin
      run_xfer(16'($urandom), 16'($urandom), 16'($urandom_range(5, 0)), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
